// File: rtl/pcie_us_fc_pkg.sv
// Shared types and constants for the PCIe flow-control credit monitor.
package pcie_us_fc_pkg;

    // cfg_fc_sel codes understood by the hard IP
    localparam logic [2:0] FC_SEL_RX_AVAIL    = 3'd0;
    localparam logic [2:0] FC_SEL_RX_LIMIT    = 3'd1;
    localparam logic [2:0] FC_SEL_RX_CONSUMED = 3'd2;
    localparam logic [2:0] FC_SEL_TX_AVAIL    = 3'd4;
    localparam logic [2:0] FC_SEL_TX_LIMIT    = 3'd5;
    localparam logic [2:0] FC_SEL_TX_CONSUMED = 3'd6;

    // ctrl_rd_field encoding
    localparam logic [3:0] FLD_PH     = 4'd0;
    localparam logic [3:0] FLD_PD     = 4'd1;
    localparam logic [3:0] FLD_NPH    = 4'd2;
    localparam logic [3:0] FLD_NPD    = 4'd3;
    localparam logic [3:0] FLD_CPLH   = 4'd4;
    localparam logic [3:0] FLD_CPLD   = 4'd5;
    localparam logic [3:0] FLD_WM_OFS = 4'd8;
    localparam logic [3:0] FLD_SWEEP  = 4'd15;

    typedef enum logic [1:0] {StPark, StWait, StCapture} fc_state_e;

    typedef struct packed {
        logic [7:0]  ph;
        logic [11:0] pd;
        logic [7:0]  nph;
        logic [11:0] npd;
        logic [7:0]  cplh;
        logic [11:0] cpld;
    } fc_fields_t;

    // Field-wise minimum of two credit snapshots
    function automatic fc_fields_t fc_min(input fc_fields_t a, input fc_fields_t b);
        fc_fields_t r;
        r.ph   = (a.ph   < b.ph)   ? a.ph   : b.ph;
        r.pd   = (a.pd   < b.pd)   ? a.pd   : b.pd;
        r.nph  = (a.nph  < b.nph)  ? a.nph  : b.nph;
        r.npd  = (a.npd  < b.npd)  ? a.npd  : b.npd;
        r.cplh = (a.cplh < b.cplh) ? a.cplh : b.cplh;
        r.cpld = (a.cpld < b.cpld) ? a.cpld : b.cpld;
        return r;
    endfunction

    // Pick one field (0..5) out of a snapshot, zero-extended to 12 bits
    function automatic logic [11:0] fc_field(input fc_fields_t f, input logic [2:0] k);
        logic [11:0] r;
        case (k)
            FLD_PH[2:0]:   r = {4'b0, f.ph};
            FLD_PD[2:0]:   r = f.pd;
            FLD_NPH[2:0]:  r = {4'b0, f.nph};
            FLD_NPD[2:0]:  r = f.npd;
            FLD_CPLH[2:0]: r = {4'b0, f.cplh};
            FLD_CPLD[2:0]: r = f.cpld;
            default:       r = 12'h000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcie_us_fc_monitor_if.sv
// Credit-status and register-read bus between the hard IP/host and the monitor.
interface pcie_us_fc_monitor_if #(
    parameter int unsigned SEL_IDX_WIDTH = 3
) ();
    logic [7:0]               cfg_fc_ph;
    logic [11:0]              cfg_fc_pd;
    logic [7:0]               cfg_fc_nph;
    logic [11:0]              cfg_fc_npd;
    logic [7:0]               cfg_fc_cplh;
    logic [11:0]              cfg_fc_cpld;
    logic [2:0]               cfg_fc_sel;
    logic                     ctrl_rd_en;
    logic [SEL_IDX_WIDTH-1:0] ctrl_rd_sel;
    logic [3:0]               ctrl_rd_field;
    logic [31:0]              ctrl_rd_data;
    logic                     ctrl_rd_valid;
    logic                     ctrl_rd_err;

    // Hard IP plus register host side
    modport master (
        output cfg_fc_ph, cfg_fc_pd, cfg_fc_nph, cfg_fc_npd, cfg_fc_cplh, cfg_fc_cpld,
        output ctrl_rd_en, ctrl_rd_sel, ctrl_rd_field,
        input  cfg_fc_sel, ctrl_rd_data, ctrl_rd_valid, ctrl_rd_err
    );

    // Monitor side
    modport slave (
        input  cfg_fc_ph, cfg_fc_pd, cfg_fc_nph, cfg_fc_npd, cfg_fc_cplh, cfg_fc_cpld,
        input  ctrl_rd_en, ctrl_rd_sel, ctrl_rd_field,
        output cfg_fc_sel, ctrl_rd_data, ctrl_rd_valid, ctrl_rd_err
    );
endinterface

// File: rtl/pcie_us_fc_record.sv
// Snapshot and low-watermark registers for one selector entry.
module pcie_us_fc_record
    import pcie_us_fc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture_i,
    input  logic       wm_clear_i,
    input  fc_fields_t sample_i,
    output fc_fields_t cur_o,
    output fc_fields_t wm_o
);
    fc_fields_t cur_q, cur_d, wm_q, wm_d, wm_base;

    // A clear coinciding with a capture restarts the watermark at the captured value
    always_comb begin
        wm_base = wm_clear_i ? '1 : wm_q;
        cur_d   = cur_q;
        wm_d    = wm_base;
        if (capture_i) begin
            cur_d = sample_i;
            wm_d  = fc_min(sample_i, wm_base);
        end
    end

    // Snapshot/watermark state
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
            wm_q  <= '1;
        end else begin
            cur_q <= cur_d;
            wm_q  <= wm_d;
        end
    end

    assign cur_o = cur_q;
    assign wm_o  = wm_q;
endmodule

// File: rtl/pcie_us_fc_monitor.sv
// Sweeps cfg_fc_sel through a selector list, captures credit fields per entry,
// tracks low watermarks and a sweep count, and serves a one-cycle read port.
module pcie_us_fc_monitor
    import pcie_us_fc_pkg::*;
#(
    parameter int unsigned            SEL_COUNT     = 2,
    parameter logic [3*SEL_COUNT-1:0] SEL_LIST      = 6'b000_100,
    parameter int unsigned            SEL_LATENCY   = 2,
    parameter int unsigned            SEL_IDX_WIDTH = 3,
    parameter int unsigned            COUNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wm_clear,
    pcie_us_fc_monitor_if.slave      bus,
    output logic                     sample_valid,
    output logic [SEL_IDX_WIDTH-1:0] sample_idx
);
    localparam int unsigned CNT_W = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;
    localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(SEL_LATENCY - 1);
    localparam logic [SEL_IDX_WIDTH-1:0] LAST_IDX = SEL_IDX_WIDTH'(SEL_COUNT - 1);

    function automatic logic [2:0] sel_code(input logic [SEL_IDX_WIDTH-1:0] i);
        return SEL_LIST[3*i +: 3];
    endfunction

    fc_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SEL_IDX_WIDTH-1:0] idx_q, idx_d, idx_next;
    logic [2:0]               sel_q, sel_d;
    logic [COUNT_WIDTH-1:0]   sweep_q, sweep_d;
    logic                     capture;
    logic                     sample_valid_q;
    logic [SEL_IDX_WIDTH-1:0] sample_idx_q;
    logic                     rd_valid_q, rd_err_q, rd_err_d;
    logic [31:0]              rd_data_q, rd_data_d;

    fc_fields_t sample, rd_cur, rd_wm;
    fc_fields_t cur [SEL_COUNT];
    fc_fields_t wm  [SEL_COUNT];

    assign sample = '{ph: bus.cfg_fc_ph, pd: bus.cfg_fc_pd, nph: bus.cfg_fc_nph,
                      npd: bus.cfg_fc_npd, cplh: bus.cfg_fc_cplh, cpld: bus.cfg_fc_cpld};

    // Sweep FSM next-state: park on entry 0, settle, capture, advance
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        sweep_d  = sweep_q;
        capture  = 1'b0;
        idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        unique case (state_q)
            StPark: begin
                idx_d = '0;
                sel_d = sel_code('0);
                cnt_d = '0;
                if (enable) state_d = StWait;
            end
            StWait: begin
                if (!enable) begin
                    state_d = StPark;
                    idx_d   = '0;
                    sel_d   = sel_code('0);
                end else if (cnt_q == LAST_CNT) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                cnt_d   = '0;
                if (idx_q == LAST_IDX) sweep_d = sweep_q + 1'b1;
                if (enable) begin
                    state_d = StWait;
                    idx_d   = idx_next;
                    sel_d   = sel_code(idx_next);
                end else begin
                    state_d = StPark;
                    idx_d   = '0;
                    sel_d   = sel_code('0);
                end
            end
            default: state_d = StPark;
        endcase
    end

    // Sweep FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StPark;
            cnt_q          <= '0;
            idx_q          <= '0;
            sel_q          <= sel_code('0);
            sweep_q        <= '0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            sel_q          <= sel_d;
            sweep_q        <= sweep_d;
            sample_valid_q <= capture;
            sample_idx_q   <= idx_q;
        end
    end

    for (genvar g = 0; g < SEL_COUNT; g++) begin : g_rec
        pcie_us_fc_record u_rec (
            .clk        (clk),
            .rst        (rst),
            .capture_i  (capture && (idx_q == SEL_IDX_WIDTH'(g))),
            .wm_clear_i (wm_clear),
            .sample_i   (sample),
            .cur_o      (cur[g]),
            .wm_o       (wm[g])
        );
    end

    // Read decode; registers are read before this cycle's capture lands
    always_comb begin
        rd_cur    = '0;
        rd_wm     = '0;
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        for (int i = 0; i < int'(SEL_COUNT); i++) begin
            if (int'(bus.ctrl_rd_sel) == i) begin
                rd_cur = cur[i];
                rd_wm  = wm[i];
            end
        end
        if (bus.ctrl_rd_field == FLD_SWEEP) begin
            rd_data_d = 32'(sweep_q);
        end else if (int'(bus.ctrl_rd_sel) >= int'(SEL_COUNT) ||
                     bus.ctrl_rd_field[2:0] > FLD_CPLD[2:0]) begin
            rd_err_d = 1'b1;
        end else if ((bus.ctrl_rd_field & FLD_WM_OFS) != 4'd0) begin
            rd_data_d = 32'(fc_field(rd_wm, bus.ctrl_rd_field[2:0]));
        end else begin
            rd_data_d = 32'(fc_field(rd_cur, bus.ctrl_rd_field[2:0]));
        end
    end

    // Read response register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.ctrl_rd_en;
            rd_data_q  <= bus.ctrl_rd_en ? rd_data_d : '0;
            rd_err_q   <= bus.ctrl_rd_en & rd_err_d;
        end
    end

    assign bus.cfg_fc_sel    = sel_q;
    assign bus.ctrl_rd_data  = rd_data_q;
    assign bus.ctrl_rd_valid = rd_valid_q;
    assign bus.ctrl_rd_err   = rd_err_q;
    assign sample_valid      = sample_valid_q;
    assign sample_idx        = sample_idx_q;
endmodule

// File: tb/tb_pcie_us_fc_monitor.sv
// Directed bench for the flow-control credit monitor (default parameters).
module tb_pcie_us_fc_monitor;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wm_clear;
    logic       sample_valid;
    logic [2:0] sample_idx;

    logic [7:0]  ph_tx, ph_rx;
    logic [11:0] pd_tx, pd_rx;

    int n_assert = 0;
    int n_fail   = 0;

    pcie_us_fc_monitor_if #(.SEL_IDX_WIDTH(3)) bus ();

    pcie_us_fc_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .wm_clear     (wm_clear),
        .bus          (bus),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx)
    );

    always #5 clk = ~clk;

    // Hard-IP model: TX-available (sel 4) and RX-available (sel 0) report different credits
    always_comb begin
        bus.cfg_fc_ph   = (bus.cfg_fc_sel == 3'd4) ? ph_tx : ph_rx;
        bus.cfg_fc_pd   = (bus.cfg_fc_sel == 3'd4) ? pd_tx : pd_rx;
        bus.cfg_fc_nph  = 8'h11;
        bus.cfg_fc_npd  = 12'h222;
        bus.cfg_fc_cplh = 8'h33;
        bus.cfg_fc_cpld = 12'h444;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idx(input logic [2:0] target, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (sample_valid === 1'b1 && sample_idx === target) found = 1'b1;
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL %s: observed no sample_valid for idx %0d expected one within 40 cycles",
                   tag, target);
        end
    endtask

    task automatic rd(input logic [2:0] sel, input logic [3:0] fld, input logic [31:0] exp_data,
                      input logic exp_err, input string tag);
        bus.ctrl_rd_en    = 1'b1;
        bus.ctrl_rd_sel   = sel;
        bus.ctrl_rd_field = fld;
        tick();
        bus.ctrl_rd_en = 1'b0;
        check({tag, "_valid"}, 32'(bus.ctrl_rd_valid), 32'd1);
        check({tag, "_data"}, bus.ctrl_rd_data, exp_data);
        check({tag, "_err"}, 32'(bus.ctrl_rd_err), 32'(exp_err));
    endtask

    initial begin
        bit seen;
        rst               = 1'b1;
        enable            = 1'b0;
        wm_clear          = 1'b0;
        bus.ctrl_rd_en    = 1'b0;
        bus.ctrl_rd_sel   = '0;
        bus.ctrl_rd_field = '0;
        ph_tx = 8'h40;
        ph_rx = 8'h20;
        pd_tx = 12'h300;
        pd_rx = 12'h0AA;
        repeat (3) tick();
        rst = 1'b0;

        // Reset and idle
        check("rst_sel", 32'(bus.cfg_fc_sel), 32'h4);
        check("rst_sv", 32'(sample_valid), 32'h0);
        check("rst_rdvalid", 32'(bus.ctrl_rd_valid), 32'h0);
        rd(3'd0, 4'd8, 32'hFF, 1'b0, "idle_wm_ph");
        rd(3'd0, 4'd9, 32'hFFF, 1'b0, "idle_wm_pd");
        rd(3'd0, 4'd15, 32'h0, 1'b0, "idle_sweep");
        tick();
        check("rdvalid_drop", 32'(bus.ctrl_rd_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= sample_valid;
        end
        check("idle_no_sample", 32'(seen), 32'h0);

        // Sweep cadence: one capture every SEL_LATENCY+1 = 3 cycles, alternating entries
        enable = 1'b1;
        wait_idx(3'd0, "first_cap");
        check("sel_after_e0", 32'(bus.cfg_fc_sel), 32'h0);
        tick();
        check("gap1_sv", 32'(sample_valid), 32'h0);
        tick();
        check("gap2_sv", 32'(sample_valid), 32'h0);
        tick();
        check("cap2_sv", 32'(sample_valid), 32'h1);
        check("cap2_idx", 32'(sample_idx), 32'h1);
        check("sel_after_e1", 32'(bus.cfg_fc_sel), 32'h4);
        rd(3'd0, 4'd0, 32'h40, 1'b0, "e0_ph");
        rd(3'd1, 4'd0, 32'h20, 1'b0, "e1_ph");
        rd(3'd1, 4'd5, 32'h444, 1'b0, "e1_cpld");

        // Entry-0 pd sequence 0x300, 0x100, 0x200
        wait_idx(3'd1, "pd_a");
        pd_tx = 12'h100;
        wait_idx(3'd0, "pd_b");
        pd_tx = 12'h200;
        wait_idx(3'd0, "pd_c");
        rd(3'd0, 4'd1, 32'h200, 1'b0, "e0_pd");
        rd(3'd0, 4'd9, 32'h100, 1'b0, "e0_wm_pd");

        // Watermark clear between captures
        pd_tx = 12'h280;
        wait_idx(3'd1, "clr_a");
        wm_clear = 1'b1;
        tick();
        wm_clear = 1'b0;
        wait_idx(3'd0, "clr_b");
        rd(3'd0, 4'd9, 32'h280, 1'b0, "wm_after_clr");

        // Clear coincident with capture of a value above the old watermark;
        // a read in the capture cycle returns the pre-capture value
        pd_tx = 12'h300;
        wait_idx(3'd1, "coin_a");
        tick();
        tick();
        wm_clear          = 1'b1;
        bus.ctrl_rd_en    = 1'b1;
        bus.ctrl_rd_sel   = 3'd0;
        bus.ctrl_rd_field = 4'd1;
        tick();
        wm_clear       = 1'b0;
        bus.ctrl_rd_en = 1'b0;
        check("coin_sv", 32'(sample_valid), 32'h1);
        check("coin_idx", 32'(sample_idx), 32'h0);
        check("coin_rd_pre", bus.ctrl_rd_data, 32'h280);
        rd(3'd0, 4'd9, 32'h300, 1'b0, "wm_coin_clr");
        rd(3'd0, 4'd1, 32'h300, 1'b0, "pd_coin");

        // Five sweeps from a fresh reset, then drop enable mid-WAIT of entry 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < 5; s++) wait_idx(3'd1, "sweep");
        wait_idx(3'd0, "pre_drop");
        enable = 1'b0;
        tick();
        check("drop_sel", 32'(bus.cfg_fc_sel), 32'h4);
        check("drop_sv", 32'(sample_valid), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= sample_valid;
        end
        check("park_no_sample", 32'(seen), 32'h0);
        rd(3'd0, 4'd15, 32'h5, 1'b0, "sweep5");

        // Invalid reads
        rd(3'd2, 4'd0, 32'h0, 1'b1, "bad_sel");
        rd(3'd0, 4'd7, 32'h0, 1'b1, "bad_f7");
        rd(3'd1, 4'd14, 32'h0, 1'b1, "bad_f14");
        rd(3'd7, 4'd15, 32'h5, 1'b0, "sweep_anysel");

        // Reset during WAIT of entry 1
        enable = 1'b1;
        wait_idx(3'd0, "pre_rst");
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_sv", 32'(sample_valid), 32'h0);
        check("rst_mid_sel", 32'(bus.cfg_fc_sel), 32'h4);
        rst    = 1'b0;
        enable = 1'b0;
        rd(3'd0, 4'd15, 32'h0, 1'b0, "rst_sweep");
        rd(3'd0, 4'd8, 32'hFF, 1'b0, "rst_wm_ph");
        rd(3'd1, 4'd9, 32'hFFF, 1'b0, "rst_wm_pd");
        rd(3'd1, 4'd0, 32'h0, 1'b0, "rst_cur_ph");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
